disparity_engine: RTL and testbench

//  Parametrised successor to the fixed-size stereo SAD block matcher.

---
 rtl/disparity_engine.sv | 186 ++++++++++++++++++
 tb/tb_disparity_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_engine.sv
// Stereo block matcher: loads a paired L/R frame, then per pixel picks the disparity with the lowest block SAD.
// Per pixel, the result appears (dmax+1)*BLOCK_SIZE^2+1 cycles after its search starts; the result is held while disp_ready is low.
module disparity_engine #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 7,
  parameter int MAX_DISP   = 14,
  parameter int HALF_BLOCK = 2,
  parameter int PIX_W      = 8,
  parameter int COORD_W    = 10,
  localparam int BLOCK_SIZE = 2*HALF_BLOCK + 1,
  localparam int DISP_W     = (MAX_DISP > 0) ? $clog2(MAX_DISP+1) : 1,
  localparam int SAD_W      = PIX_W + $clog2(BLOCK_SIZE*BLOCK_SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_left,
  input  logic [PIX_W-1:0]   pix_right,
  input  logic [SAD_W-1:0]   sad_thresh,
  output logic               disp_valid,
  input  logic               disp_ready,
  output logic [DISP_W-1:0]  disp_data,
  output logic               disp_invalid,
  output logic [COORD_W-1:0] disp_x,
  output logic [COORD_W-1:0] disp_y,
  output logic               disp_last,
  output logic               busy,
  output logic [1:0]         state
);

  localparam int NPIX   = WIDTH*HEIGHT;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int OFF_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_COMPUTE = 2'd2, S_EMIT = 2'd3} state_t;
  state_t r_state, w_next_state;

  logic [PIX_W-1:0]   r_left_mem  [NPIX];
  logic [PIX_W-1:0]   r_right_mem [NPIX];
  logic [ADDR_W-1:0]  r_waddr;
  logic [COORD_W-1:0] r_px, r_py;
  logic [DISP_W-1:0]  r_d, r_best_d, w_dmax;
  logic [OFF_W-1:0]   r_dx, r_dy;
  logic [SAD_W-1:0]   r_acc, r_best_sad, w_term, w_total;
  logic               r_disp_valid, r_disp_invalid, r_disp_last;
  logic [DISP_W-1:0]  r_disp_data;
  logic [COORD_W-1:0] r_disp_x, r_disp_y;

  int                 w_lx, w_ly, w_rx;
  logic               w_inframe, w_last_beat, w_last_term, w_last_px;
  logic [ADDR_W-1:0]  w_laddr, w_raddr;
  logic [PIX_W-1:0]   w_lpix, w_rpix, w_diff;

  assign w_last_beat = (r_waddr == ADDR_W'(NPIX-1));
  assign w_last_term = (r_dx == OFF_W'(BLOCK_SIZE-1)) && (r_dy == OFF_W'(BLOCK_SIZE-1));
  assign w_last_px   = (r_px == COORD_W'(WIDTH-1)) && (r_py == COORD_W'(HEIGHT-1));
  assign w_dmax      = (int'(r_px) >= MAX_DISP) ? DISP_W'(MAX_DISP) : DISP_W'(r_px);

  // Window offsets run 0..BLOCK_SIZE-1; anything touching outside the frame contributes 0.
  assign w_lx      = int'(r_px) + int'(r_dx) - HALF_BLOCK;
  assign w_ly      = int'(r_py) + int'(r_dy) - HALF_BLOCK;
  assign w_rx      = w_lx - int'(r_d);
  assign w_inframe = (w_lx >= 0) && (w_lx < WIDTH) && (w_ly >= 0) && (w_ly < HEIGHT) && (w_rx >= 0);
  assign w_laddr   = w_inframe ? ADDR_W'(w_ly*WIDTH + w_lx) : '0;
  assign w_raddr   = w_inframe ? ADDR_W'(w_ly*WIDTH + w_rx) : '0;
  assign w_lpix    = r_left_mem[w_laddr];
  assign w_rpix    = r_right_mem[w_raddr];
  assign w_diff    = (w_lpix > w_rpix) ? (w_lpix - w_rpix) : (w_rpix - w_lpix);
  assign w_term    = w_inframe ? SAD_W'(w_diff) : '0;
  assign w_total   = r_acc + w_term;

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && pix_valid) begin
      r_left_mem[r_waddr]  <= pix_left;
      r_right_mem[r_waddr] <= pix_right;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_LOAD;
      S_LOAD:    if (pix_valid && w_last_beat) w_next_state = S_COMPUTE;
      S_COMPUTE: if (w_last_term && (r_d == w_dmax)) w_next_state = S_EMIT;
      S_EMIT:    if (r_disp_valid && disp_ready) w_next_state = r_disp_last ? S_IDLE : S_COMPUTE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_waddr        <= '0;
      r_px           <= '0;
      r_py           <= '0;
      r_d            <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_acc          <= '0;
      r_best_sad     <= '0;
      r_best_d       <= '0;
      r_disp_valid   <= 1'b0;
      r_disp_invalid <= 1'b0;
      r_disp_last    <= 1'b0;
      r_disp_data    <= '0;
      r_disp_x       <= '0;
      r_disp_y       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_waddr <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_d     <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_acc   <= '0;
          end
        end
        S_LOAD: begin
          if (pix_valid) r_waddr <= r_waddr + ADDR_W'(1);
        end
        S_COMPUTE: begin
          if (w_last_term) begin
            if ((r_d == '0) || (w_total < r_best_sad)) begin
              r_best_sad <= w_total;
              r_best_d   <= r_d;
            end
            r_acc <= '0;
            r_dx  <= '0;
            r_dy  <= '0;
            r_d   <= (r_d == w_dmax) ? '0 : r_d + DISP_W'(1);
          end else begin
            r_acc <= w_total;
            if (r_dx == OFF_W'(BLOCK_SIZE-1)) begin
              r_dx <= '0;
              r_dy <= r_dy + OFF_W'(1);
            end else begin
              r_dx <= r_dx + OFF_W'(1);
            end
          end
        end
        S_EMIT: begin
          // First EMIT cycle captures the finished search; later cycles wait for the handshake.
          if (!r_disp_valid) begin
            r_disp_valid   <= 1'b1;
            r_disp_data    <= r_best_d;
            r_disp_x       <= r_px;
            r_disp_y       <= r_py;
            r_disp_last    <= w_last_px;
            r_disp_invalid <= (sad_thresh != '0) && (r_best_sad > sad_thresh);
          end else if (disp_ready) begin
            r_disp_valid <= 1'b0;
            if (!r_disp_last) begin
              if (r_px == COORD_W'(WIDTH-1)) begin
                r_px <= '0;
                r_py <= r_py + COORD_W'(1);
              end else begin
                r_px <= r_px + COORD_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_ready    = (r_state == S_LOAD);
  assign busy         = (r_state != S_IDLE);
  assign state        = r_state;
  assign disp_valid   = r_disp_valid;
  assign disp_data    = r_disp_data;
  assign disp_invalid = r_disp_invalid;
  assign disp_x       = r_disp_x;
  assign disp_y       = r_disp_y;
  assign disp_last    = r_disp_last;

endmodule

// File: tb/tb_disparity_engine.sv
// Bench: default-size engine for texture/latency/stall tests, small degenerate-height engine for the rest.
module tb_disparity_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, pix_valid = 1'b0, disp_ready = 1'b0;
  logic [7:0] pix_left = '0, pix_right = '0;
  logic [12:0] thr_a = '0;
  logic [11:0] thr_b = '0;
  logic sel = 1'b0;

  logic a_rdy, a_vld, a_inv, a_last, a_busy;
  logic [3:0] a_data;
  logic [9:0] a_x, a_y;
  logic [1:0] a_st;
  logic b_rdy, b_vld, b_inv, b_last, b_busy;
  logic [1:0] b_data;
  logic [9:0] b_x, b_y;
  logic [1:0] b_st;

  int errors = 0, checks = 0;
  int mw, mh, mmd, mhb, thr;
  int lm [0:6][0:19];
  int rm [0:6][0:19];

  always #5 clk = ~clk;

  disparity_engine dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .pix_valid(pix_valid), .pix_ready(a_rdy),
    .pix_left(pix_left), .pix_right(pix_right), .sad_thresh(thr_a), .disp_valid(a_vld),
    .disp_ready(disp_ready), .disp_data(a_data), .disp_invalid(a_inv), .disp_x(a_x),
    .disp_y(a_y), .disp_last(a_last), .busy(a_busy), .state(a_st));

  disparity_engine #(.WIDTH(8), .HEIGHT(2), .MAX_DISP(3), .HALF_BLOCK(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .pix_valid(pix_valid), .pix_ready(b_rdy),
    .pix_left(pix_left), .pix_right(pix_right), .sad_thresh(thr_b), .disp_valid(b_vld),
    .disp_ready(disp_ready), .disp_data(b_data), .disp_invalid(b_inv), .disp_x(b_x),
    .disp_y(b_y), .disp_last(b_last), .busy(b_busy), .state(b_st));

  logic o_rdy, o_vld, o_inv, o_last, o_busy;
  logic [3:0] o_data;
  logic [9:0] o_x, o_y;
  logic [1:0] o_st;
  assign o_rdy  = sel ? b_rdy  : a_rdy;
  assign o_vld  = sel ? b_vld  : a_vld;
  assign o_inv  = sel ? b_inv  : a_inv;
  assign o_last = sel ? b_last : a_last;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_data = sel ? {2'b00, b_data} : a_data;
  assign o_x    = sel ? b_x : a_x;
  assign o_y    = sel ? b_y : a_y;
  assign o_st   = sel ? b_st : a_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Direct SAD search over the stored images, independent of any cycle schedule.
  function automatic int ref_disp(input int x, input int y, output int sad);
    int best, bd, s, lx, ly, rx, dm;
    best = 0; bd = 0;
    dm = (x < mmd) ? x : mmd;
    for (int d = 0; d <= dm; d++) begin
      s = 0;
      for (int dy = -mhb; dy <= mhb; dy++)
        for (int dx = -mhb; dx <= mhb; dx++) begin
          lx = x + dx; ly = y + dy; rx = lx - d;
          if (lx >= 0 && lx < mw && ly >= 0 && ly < mh && rx >= 0)
            s += (lm[ly][lx] > rm[ly][rx]) ? lm[ly][lx] - rm[ly][rx] : rm[ly][rx] - lm[ly][lx];
        end
      if (d == 0 || s < best) begin best = s; bd = d; end
    end
    sad = best;
    return bd;
  endfunction

  task automatic set_frame(input int mode);
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 20; x++) begin
        case (mode)
          0: begin lm[y][x] = 'h40; rm[y][x] = 'h40; end
          1: begin lm[y][x] = 'hFF; rm[y][x] = 'h00; end
          default: begin lm[y][x] = $urandom_range(0, 255); rm[y][x] = $urandom_range(0, 255); end
        endcase
      end
    if (mode == 3)
      for (int y = 0; y < 7; y++)
        for (int x = 0; x < 20; x++)
          rm[y][x] = (x + 3 < 20) ? lm[y][x+3] : $urandom_range(0, 255);
  endtask

  task automatic set_thr(input int t);
    thr = t; thr_a = 13'(t); thr_b = 12'(t);
  endtask

  task automatic drive_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic load_frame(input bit mid_start);
    int n, beat, cyc;
    bit pend;
    n = mw * mh; beat = 0; cyc = 0; pend = 0;
    @(negedge clk); drive_start(1'b1);
    @(negedge clk); drive_start(1'b0);
    check("load_entered", o_st, 1);
    while (beat < n && cyc < 4*n + 100) begin
      if (pend) begin check("mid_start_ignored", o_st, 1); pend = 0; end
      drive_start(1'b0);
      if (mid_start && beat == n/2 && cyc < 2*n) begin drive_start(1'b1); pend = 1; mid_start = 0; end
      pix_left  = 8'(lm[beat / mw][beat % mw]);
      pix_right = 8'(rm[beat / mw][beat % mw]);
      pix_valid = ($urandom_range(0, 3) != 0);
      if (pix_valid && o_rdy) beat++;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    drive_start(1'b0);
    check("load_beats", beat, n);
  endtask

  task automatic collect(input bit measure_lat, input int stall_x, input int stall_y);
    int n, k, cyc, first, stall, sad, ed, ex, ey;
    bit have_snap, rdy;
    logic [3:0] s_data; logic [9:0] s_x, s_y; logic s_last, s_inv;
    n = mw * mh; k = 0; cyc = 0; first = -1; stall = 0; have_snap = 0;
    disp_ready = 1'b0;
    while (k < n && cyc < 60000) begin
      if (cyc == 0) begin
        check("compute_entered", o_st, 2);
        check("pix_ready_drop", o_rdy, 0);
      end
      if (have_snap) begin
        check("hold_valid", o_vld, 1);
        check("hold_data", o_data, s_data);
        check("hold_x", o_x, s_x);
        check("hold_y", o_y, s_y);
        check("hold_last", o_last, s_last);
        check("hold_invalid", o_inv, s_inv);
      end
      if (o_vld) begin
        if (first < 0) first = cyc;
        if (int'(o_x) == stall_x && int'(o_y) == stall_y && stall < 10) begin rdy = 0; stall++; end
        else rdy = ($urandom_range(0, 2) != 0);
        if (rdy) begin
          ex = k % mw; ey = k / mw;
          ed = ref_disp(ex, ey, sad);
          check("out_x", o_x, ex);
          check("out_y", o_y, ey);
          check("out_data", o_data, ed);
          check("out_invalid", o_inv, (thr != 0 && sad > thr) ? 1 : 0);
          check("out_last", o_last, (k == n-1) ? 1 : 0);
          if (!sel && ex >= 5 && ex <= 16 && ey >= 2 && ey <= 4) check("shift3_disp", o_data, 3);
          k++;
          have_snap = 0;
        end else begin
          s_data = o_data; s_x = o_x; s_y = o_y; s_last = o_last; s_inv = o_inv;
          have_snap = 1;
        end
      end else begin
        rdy = ($urandom_range(0, 1) != 0);
        have_snap = 0;
      end
      disp_ready = rdy;
      @(negedge clk);
      cyc++;
    end
    disp_ready = 1'b0;
    check("frame_outputs", k, n);
    if (measure_lat) check("first_pixel_latency", first, 26);
    if (stall_x >= 0) check("stall_cycles", stall, 10);
    check("idle_after_frame", o_st, 0);
    check("valid_after_frame", o_vld, 0);
    check("busy_after_frame", o_busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, o_st, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_pix_ready"}, o_rdy, 0);
    check({tag, "_disp_valid"}, o_vld, 0);
    check({tag, "_disp_data"}, o_data, 0);
    check({tag, "_disp_x"}, o_x, 0);
    check({tag, "_disp_y"}, o_y, 0);
    check({tag, "_disp_last"}, o_last, 0);
    check({tag, "_disp_invalid"}, o_inv, 0);
  endtask

  initial begin
    set_thr(0);
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 check_reset_outputs("rst_a");
    sel = 1'b1; #1 check_reset_outputs("rst_b");
    @(negedge clk) reset_n = 1'b1;

    // Full-size frame: shifted texture, latency of pixel (0,0), 10-cycle stall on (4,2).
    sel = 1'b0; mw = 20; mh = 7; mmd = 14; mhb = 2;
    set_frame(3); set_thr($urandom_range(1, 2500));
    load_frame(0);
    collect(1, 4, 2);

    // Small engine, height below block size.
    sel = 1'b1; mw = 8; mh = 2; mmd = 3; mhb = 1;
    set_frame(0); set_thr(0);
    load_frame(0); collect(0, -1, -1);
    set_frame(1); set_thr(1);
    load_frame(0); collect(0, -1, -1);
    set_thr(0);
    load_frame(0); collect(0, -1, -1);

    // Ignored start mid-load, then reset while computing.
    set_frame(2); set_thr($urandom_range(1, 1500));
    load_frame(1);
    repeat (5) @(negedge clk);
    check("pre_reset_compute", o_st, 2);
    reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", o_st, 0);

    set_frame(2); set_thr($urandom_range(0, 1500));
    load_frame(0); collect(0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
